count_display: RTL
==================

// Module: count_display
// PURPOSE
//  Downstream stage of the debounced push-button counter: consumes the 8-bit count
//  and shows it in decimal on a 4-digit multiplexed, common-anode seven-segment display.
//  A sequential double-dabble converter turns binary into 3 BCD digits; a refresh
//  scanner time-multiplexes the digits. Sits beside the counter inside the board top.
// PARAMETERS
//  REFRESH_DIV  100000  clock cycles each digit is lit (1 kHz/digit at 100 MHz); must be >= 2
// PORTS
//  clock    in   1  system clock; all state on rising edge
//  reset    in   1  asynchronous, active-high reset
//  count    in   8  binary value from counter, 0..255
//  an       out  4  digit enables, active-low, one-hot-low; an[0] = ones digit
//  seg      out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp       out  1  decimal point, active-low; constant 1 (off)
//  busy     out  1  high while a conversion is in progress
// BEHAVIOUR
//  Reset (async assert): an=4'b1111, seg=7'b1111111, dp=1, busy=0, digit regs
//   {hund,tens,ones}=0, last-converted value=0, refresh counter=0, digit index=0, FSM=IDLE.
//  Converter FSM (IDLE -> SHIFT -> LOAD -> IDLE):
//   IDLE : if count != last-converted, capture count into 8-bit shift reg, clear 12-bit
//          BCD scratch, bit counter=0, go SHIFT, busy=1 next cycle.
//   SHIFT: per cycle, add 3 to every scratch nibble >= 5, then shift {scratch,shift} left 1;
//          after the 8th shift go LOAD.
//   LOAD : copy scratch into {hund,tens,ones}, last-converted = captured value, busy=0, IDLE.
//   Latency: display digit regs update exactly 10 rising edges after the edge on which
//   a changed count is first sampled in IDLE (1 capture + 8 shift + 1 load).
//  Digit regs change only in LOAD; partial BCD is never displayed.
//  count changing during SHIFT/LOAD is ignored; IDLE re-compares and reconverts the
//   newest value. Count wrap 255->0 is just another change (shows 0).
//  Scanner: refresh counter counts 0..REFRESH_DIV-1, at terminal value wraps to 0 and
//   digit index advances 0->1->2->3->0. Independent of converter state.
//   Index 0: ones, 1: tens, 2: hundreds, 3: blank (an[3] low, seg all 1s).
//  an/seg are registered: driven on the edge after index/digit regs, no glitches
//   between digits; exactly one an bit low at all times after first post-reset edge.
//  Seg encoding: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000 ({g..a}); BCD >9 cannot occur, decode blank.
//  Reset mid-conversion: FSM returns to IDLE, display shows 0; if count is nonzero after
//   release, a full conversion starts from the first post-reset edge.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: hundreds digit blank (seg=7'h7F) when hund==0; tens
//   blank when hund==0 and tens==0; ones always shown (value 0 shows single "0").
//   an still cycles normally on blanked digits.
//  Not defined: all three digits always shown, e.g. 7 shows "007".
// STRUCTURE
//  Shared include display_defs.vh: seven-segment pattern constants (digits 0-9, BLANK),
//   FSM state encodings (IDLE/SHIFT/LOAD), digit-index constants.
//  Sub-module bin2bcd_seq: the converter FSM (ports clock, reset, bin[7:0], start,
//   busy, bcd[11:0], done). count_display holds compare logic, scanner and decode.
// TESTING (REFRESH_DIV=4 in simulation)
//  Reset asserted mid-scan -> an=1111, seg=1111111 immediately (async), busy=0.
//  count 0->123 held -> busy high 9 cycles; 10 edges later digits 1,2,3 scanned on
//   an=1110:0110000, an=1101:0100100, an=1011:1111001, an=0111:blank.
//  count 255 then 0 (wrap) -> shows 255 then 000 (blank-blank-0 with LEADING_ZERO_BLANK_EN).
//  count 45 changed to 99 on 3rd SHIFT cycle -> display goes 45 then 99, never a mix.
//  count 7, build without/with LEADING_ZERO_BLANK_EN -> "007" vs hundreds/tens segs 1111111.
//  Scanner: check each an one-hot-low for exactly REFRESH_DIV cycles, order 0,1,2,3; dp=1.

Source files
------------

// File: rtl/count_display_pkg.sv
// Shared definitions for the count_display slice: converter FSM encoding,
// seven-segment patterns ({g,f,e,d,c,b,a}, active-low), digit-index codes
// and the small helpers used by the converter and the display decode.
package count_display_pkg;

  // Converter FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StLoad  = 2'd2
  } conv_state_e;

  // Scanner digit positions; an[index] is pulled low while that position is lit.
  localparam logic [1:0] DigOnes  = 2'd0;
  localparam logic [1:0] DigTens  = 2'd1;
  localparam logic [1:0] DigHund  = 2'd2;
  localparam logic [1:0] DigBlank = 2'd3;

  // Common-anode segment patterns, a segment is lit when its bit is 0.
  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;
  localparam logic [6:0] SegBlank = 7'b1111111;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the next shift, so bias it by 3 first.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // BCD digit to segment pattern; codes above 9 never occur and decode blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = Seg0;
      4'd1:    pat = Seg1;
      4'd2:    pat = Seg2;
      4'd3:    pat = Seg3;
      4'd4:    pat = Seg4;
      4'd5:    pat = Seg5;
      4'd6:    pat = Seg6;
      4'd7:    pat = Seg7;
      4'd8:    pat = Seg8;
      4'd9:    pat = Seg9;
      default: pat = SegBlank;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to 3 BCD digits.
// One capture cycle, eight shift cycles, one load cycle. The bcd output only
// changes in the load cycle, so a partially converted value is never visible.
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  bin,
  input  logic        start,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        done
);

  conv_state_e state_q, state_d;

  logic [7:0]  shift_q;
  logic [11:0] scratch_q;
  logic [11:0] scratch_adj;
  logic [2:0]  bit_cnt_q;
  logic [11:0] bcd_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: capture on start, eight shifts, then one load cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (bit_cnt_q == 3'd7) state_d = StLoad;
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Per-nibble +3 correction applied before each shift.
  always_comb begin
    scratch_adj[3:0]  = add3(scratch_q[3:0]);
    scratch_adj[7:4]  = add3(scratch_q[7:4]);
    scratch_adj[11:8] = add3(scratch_q[11:8]);
  end

  // Datapath: shift register, BCD scratch, bit counter and the result register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q   <= 8'd0;
      scratch_q <= 12'd0;
      bit_cnt_q <= 3'd0;
      bcd_q     <= 12'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= 12'd0;
            bit_cnt_q <= 3'd0;
          end
        end
        StShift: begin
          // {scratch, shift} <<= 1 after correction; MSB of shift enters BCD LSB.
          scratch_q <= {scratch_adj[10:0], shift_q[7]};
          shift_q   <= {shift_q[6:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        StLoad: begin
          bcd_q <= scratch_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs: busy spans shift and load cycles; done marks the load cycle.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StLoad);
    bcd  = bcd_q;
  end

endmodule

// File: rtl/count_display.sv
// Decimal display of an 8-bit count on a 4-digit multiplexed common-anode
// seven-segment display. A change of count starts a bin2bcd_seq conversion;
// a free-running scanner lights ones, tens, hundreds and a blank position in
// turn, each for REFRESH_DIV cycles.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (hundreds when zero, tens when hundreds and tens are both zero).
module count_display
  import count_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] count,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int unsigned RefreshW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RefreshW-1:0] RefreshLast = RefreshW'(REFRESH_DIV - 1);

  // Converter handshake and held values.
  logic        conv_busy;
  logic        conv_done;
  logic        conv_start;
  logic [11:0] conv_bcd;
  logic [7:0]  cap_q;
  logic [7:0]  last_q;

  // Scanner state.
  logic [RefreshW-1:0] refresh_q;
  logic [1:0]          idx_q;

  // Display decode.
  logic [3:0] hund, tens, ones;
  logic       hund_blank, tens_blank;
  logic [3:0] an_d, an_q;
  logic [6:0] seg_d, seg_q;

  // Only start while the converter is idle; a count that moves during a
  // conversion is picked up by the next idle comparison.
  assign conv_start = ~conv_busy & (count != last_q);

  bin2bcd_seq u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .bin   (count),
    .start (conv_start),
    .busy  (conv_busy),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // Track the value being converted and the value currently displayed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_q  <= 8'd0;
      last_q <= 8'd0;
    end else begin
      if (conv_start) cap_q <= count;
      if (conv_done)  last_q <= cap_q;
    end
  end

  // Refresh counter and digit index, free-running regardless of converter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      idx_q     <= DigOnes;
    end else if (refresh_q == RefreshLast) begin
      refresh_q <= '0;
      idx_q     <= idx_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  assign hund = conv_bcd[11:8];
  assign tens = conv_bcd[7:4];
  assign ones = conv_bcd[3:0];

  // Leading-zero suppression flags (always clear in the default build).
  always_comb begin
    hund_blank = 1'b0;
    tens_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    hund_blank = (hund == 4'd0);
    tens_blank = (hund == 4'd0) && (tens == 4'd0);
`endif
  end

  // Digit select and segment decode for the current scan position.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SegBlank;
    unique case (idx_q)
      DigOnes: begin
        an_d  = 4'b1110;
        seg_d = seg_decode(ones);
      end
      DigTens: begin
        an_d  = 4'b1101;
        seg_d = tens_blank ? SegBlank : seg_decode(tens);
      end
      DigHund: begin
        an_d  = 4'b1011;
        seg_d = hund_blank ? SegBlank : seg_decode(hund);
      end
      DigBlank: begin
        an_d  = 4'b0111;
        seg_d = SegBlank;
      end
      default: ;
    endcase
  end

  // Register an/seg together so digit changes never glitch across positions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_q  <= 4'b1111;
      seg_q <= SegBlank;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = conv_busy;

endmodule
